// File: rtl/edlo_sequencer_if.sv
// Datapath issue channel between edlo_sequencer and the ALU/memory-controller pair.
// The sequencer is master: it presents {dp_inst, dp_addr} with dp_valid; the datapath answers dp_ready.
interface edlo_sequencer_if #(
    parameter int ADDR_BITS = 4
);
    logic [3:0]           dp_inst;
    logic [ADDR_BITS-1:0] dp_addr;
    logic                 dp_valid;
    logic                 dp_ready;

    modport master (
        output dp_inst,
        output dp_addr,
        output dp_valid,
        input  dp_ready
    );

    modport slave (
        input  dp_inst,
        input  dp_addr,
        input  dp_valid,
        output dp_ready
    );
endinterface

// File: rtl/edlo_sequencer.sv
// Program sequencer: runs a host-loaded 16-word program, issuing {inst, addr} operations
// to the datapath and handling JMP/HALT internally, with a stall timeout fault.
module edlo_sequencer #(
    parameter int PROG_BITS = 4,
    parameter int ADDR_BITS = 4,
    parameter int WAIT_MAX  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_en,
    input  logic [PROG_BITS-1:0]   load_addr,
    input  logic [3+ADDR_BITS:0]   load_data,
    input  logic                   start,
    input  logic                   stop,
    edlo_sequencer_if.master       dp,
    output logic [PROG_BITS-1:0]   pc,
    output logic                   running,
    output logic                   halted,
    output logic                   error
);
    localparam int unsigned DEPTH  = 2**PROG_BITS;
    localparam int          WORD_W = 4 + ADDR_BITS;
    localparam int          TMO_W  = $clog2(WAIT_MAX + 1);

    localparam logic [3:0]           OP_HALT  = 4'hF;
    localparam logic [3:0]           OP_JMP   = 4'hE;
    localparam logic [PROG_BITS-1:0] PC_LAST  = '1;
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_e;

    state_e               state_q;
    logic [PROG_BITS-1:0] pc_q;
    logic [WORD_W-1:0]    ir_q;
    logic [TMO_W-1:0]     tmo_q;
    logic                 dp_valid_q;
    logic [3:0]           dp_inst_q;
    logic [ADDR_BITS-1:0] dp_addr_q;
    logic [WORD_W-1:0]    store_q [DEPTH];

    logic [WORD_W-1:0]    fetch_word;
    logic [3:0]           fetch_inst;
    logic [ADDR_BITS-1:0] fetch_addr;
    logic [3:0]           ir_inst;
    logic [ADDR_BITS-1:0] ir_addr;
    logic [PROG_BITS-1:0] jmp_pc;
    logic                 idle_state;

    always_comb begin
        fetch_word = store_q[pc_q];
        fetch_inst = fetch_word[WORD_W-1 -: 4];
        fetch_addr = fetch_word[ADDR_BITS-1:0];
        ir_inst    = ir_q[WORD_W-1 -: 4];
        ir_addr    = ir_q[ADDR_BITS-1:0];
        jmp_pc     = PROG_BITS'(ir_addr);
        idle_state = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR);
    end

    // Writes are accepted only while no program is executing; reset refills with HALT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store_q[i] <= '1;
            end
        end else if (load_en && idle_state) begin
            store_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            tmo_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_inst_q  <= '0;
            dp_addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (start && stop) begin
                        state_q <= S_HALTED;
                    end else if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
                        tmo_q   <= '0;
                    end
                end

                // Issue fields are registered here so dp_valid rises one edge after FETCH.
                S_FETCH: begin
                    if (stop) begin
                        state_q <= S_HALTED;
                    end else begin
                        ir_q    <= fetch_word;
                        tmo_q   <= '0;
                        state_q <= S_EXEC;
                        if ((fetch_inst != OP_HALT) && (fetch_inst != OP_JMP)) begin
                            dp_valid_q <= 1'b1;
                            dp_inst_q  <= fetch_inst;
                            dp_addr_q  <= fetch_addr;
                        end
                    end
                end

                S_EXEC: begin
                    if (stop) begin
                        state_q    <= S_HALTED;
                        dp_valid_q <= 1'b0;
                        dp_inst_q  <= '0;
                        dp_addr_q  <= '0;
                    end else if (ir_inst == OP_HALT) begin
                        state_q <= S_HALTED;
                    end else if (ir_inst == OP_JMP) begin
                        pc_q    <= jmp_pc;
                        state_q <= S_FETCH;
                    end else if (dp.dp_ready) begin
                        dp_valid_q <= 1'b0;
                        dp_inst_q  <= '0;
                        dp_addr_q  <= '0;
                        if (pc_q == PC_LAST) begin
                            state_q <= S_HALTED;
                        end else begin
                            pc_q    <= pc_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q    <= S_ERROR;
                        dp_valid_q <= 1'b0;
                        dp_inst_q  <= '0;
                        dp_addr_q  <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dp.dp_valid = dp_valid_q;
    assign dp.dp_inst  = dp_inst_q;
    assign dp.dp_addr  = dp_addr_q;
    assign pc          = pc_q;
    assign running     = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALTED);
    assign error       = (state_q == S_ERROR);
endmodule

// File: tb/tb_edlo_sequencer.sv
// Directed-vector bench for edlo_sequencer with hand-computed expectations.
module tb_edlo_sequencer;
    logic       clk;
    logic       rst_n;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       start;
    logic       stop;
    logic [3:0] pc;
    logic       running;
    logic       halted;
    logic       error;

    edlo_sequencer_if #(.ADDR_BITS(4)) dp_if ();

    edlo_sequencer #(
        .PROG_BITS (4),
        .ADDR_BITS (4),
        .WAIT_MAX  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .stop      (stop),
        .dp        (dp_if),
        .pc        (pc),
        .running   (running),
        .halted    (halted),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vcycles = 0;
    logic [7:0] xq [$];
    int         xt [$];

    always @(posedge clk) cyc++;

    // An operation is transferred on an edge where valid&ready and no stop abandons it.
    always @(negedge clk) begin
        if (rst_n && dp_if.dp_valid) begin
            vcycles++;
            if (dp_if.dp_ready && !stop) begin
                xq.push_back({dp_if.dp_inst, dp_if.dp_addr});
                xt.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vcycles = 0;
        xq.delete();
        xt.delete();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        stop      = 1'b0;
        dp_if.dp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [15:0] outs();
        return {dp_if.dp_valid, dp_if.dp_inst, dp_if.dp_addr, pc, running, halted, error};
    endfunction

    int bad;

    initial begin
        do_reset();
        check("reset_outs", 32'(outs()), 32'h0);

        // Three-word program: two issues then HALT.
        load(4'd0, 8'h13);
        load(4'd1, 8'h25);
        load(4'd2, 8'hF0);
        dp_if.dp_ready = 1'b1;
        clear_mon();
        pulse_start();
        check("lat_fetch", 32'({running, dp_if.dp_valid}), 32'h2);
        tick();
        check("lat_valid", 32'({dp_if.dp_valid, dp_if.dp_inst, dp_if.dp_addr}), 32'h113);
        for (int i = 0; i < 20 && !halted; i++) tick();
        check("t1_halted", 32'(halted), 32'h1);
        check("t1_pc", 32'(pc), 32'h2);
        check("t1_nxfer", 32'(xq.size()), 32'd2);
        if (xq.size() == 2) begin
            check("t1_x0", 32'(xq[0]), 32'h13);
            check("t1_x1", 32'(xq[1]), 32'h25);
            check("t1_gap", 32'(xt[1] - xt[0]), 32'd2);
        end
        check("t1_idle_outs", 32'({dp_if.dp_valid, running}), 32'h0);

        // Endless JMP loop; stop lands on an edge where the issue would have transferred.
        do_reset();
        load(4'd0, 8'h12);
        load(4'd1, 8'hE0);
        dp_if.dp_ready = 1'b1;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 17; i++) tick();
        check("t2_valid_pre", 32'({dp_if.dp_valid, dp_if.dp_inst, dp_if.dp_addr}), 32'h112);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t2_halted", 32'({halted, running, dp_if.dp_valid}), 32'h4);
        check("t2_pc_abandon", 32'(pc), 32'h0);
        check("t2_nxfer", 32'(xq.size()), 32'd4);
        bad = 0;
        foreach (xq[i]) if (xq[i] != 8'h12) bad++;
        for (int i = 1; i < xt.size(); i++) if (xt[i] - xt[i-1] != 4) bad++;
        check("t2_period4", 32'(bad), 32'd0);

        // Stalled datapath: eight valid cycles then fault at pc 0.
        do_reset();
        load(4'd0, 8'h34);
        dp_if.dp_ready = 1'b0;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 30 && !error; i++) tick();
        check("t3_error", 32'({error, halted, running, dp_if.dp_valid}), 32'h8);
        check("t3_pc", 32'(pc), 32'h0);
        check("t3_vcycles", 32'(vcycles), 32'd8);
        dp_if.dp_ready = 1'b1;
        pulse_start();
        check("t3_restart", 32'({error, running}), 32'h1);
        for (int i = 0; i < 20 && !halted; i++) tick();

        // Full store of issues: no pc wrap after the last word.
        do_reset();
        for (int i = 0; i < 16; i++) load(4'(i), 8'h11);
        dp_if.dp_ready = 1'b1;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 60 && !halted; i++) tick();
        check("t4_halted", 32'(halted), 32'h1);
        check("t4_pc", 32'(pc), 32'hF);
        check("t4_nxfer", 32'(xq.size()), 32'd16);
        bad = 0;
        foreach (xq[i]) if (xq[i] != 8'h11) bad++;
        check("t4_words", 32'(bad), 32'd0);

        // Loads during execution must not land.
        do_reset();
        load(4'd0, 8'h12);
        load(4'd1, 8'hE0);
        dp_if.dp_ready = 1'b1;
        pulse_start();
        load_data = 8'hF0;
        for (int i = 0; i < 6; i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i % 2);
            tick();
        end
        load_en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 8; i++) tick();
        check("t5_rerun", 32'({running, halted}), 32'h2);
        check("t5_nxfer", 32'(xq.size()), 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t5_start_stop", 32'({halted, running, pc}), 32'h20);

        // Reset in EXEC, then start with the refilled (all-HALT) store.
        do_reset();
        load(4'd0, 8'h34);
        dp_if.dp_ready = 1'b0;
        pulse_start();
        tick();
        tick();
        check("t6_valid_pre", 32'(dp_if.dp_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        check("t6_reset_outs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 5 && !halted; i++) tick();
        check("t6_halt_pc", 32'({halted, pc}), 32'h10);
        check("t6_no_valid", 32'(vcycles), 32'd0);

        // Load and start in the same idle cycle: FETCH sees the new word.
        do_reset();
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 8'h27;
        start     = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        tick();
        check("t7_load_start", 32'({dp_if.dp_valid, dp_if.dp_inst, dp_if.dp_addr}), 32'h127);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
